// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick, mid-bit strobe and bit tick from a
// runtime-loadable integer+fraction divisor with double-buffered configuration.
module baud_gen_frac #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OSR      = 16,
  parameter int unsigned DEF_INT  = 325,
  parameter int unsigned DEF_FRAC = 8,
  localparam int unsigned PH_W    = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  act_int_q, act_int_d, shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              os_q, os_d, mid_q, mid_d, bit_q, bit_d;

  logic [FRAC_W:0]   frac_sum;
  logic [CNT_W:0]    last_cnt;
  logic              wrap, issue, apply;

  // The carry of this interval's fraction add stretches this interval by one cycle.
  assign frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign last_cnt = {1'b0, act_int_q} + (CNT_W+1)'(frac_sum[FRAC_W]) - (CNT_W+1)'(1);

  // >= rather than == so a divisor shrunk while frozen cannot strand the counter.
  assign wrap  = en && !err_q && ({1'b0, cnt_q} >= last_cnt);
  assign issue = wrap && !resync;
  assign apply = pend_q && (issue || resync || !en || err_q);

  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ph_d       = ph_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    os_d       = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;

    if (apply) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
      pend_d     = 1'b0;
    end
    if (div_load) begin
      shd_int_d  = div_int;
      shd_frac_d = div_frac;
      pend_d     = 1'b1;
    end

    err_d = (act_int_d < CNT_W'(2));

    if (err_d || resync) begin
      cnt_d = '0;
      acc_d = '0;
      ph_d  = '0;
    end else if (en && !err_q) begin
      if (wrap) begin
        cnt_d = '0;
        acc_d = frac_sum[FRAC_W-1:0];
        ph_d  = ph_q + PH_W'(1);
        os_d  = 1'b1;
        mid_d = (ph_q == PH_W'(OSR/2 - 1));
        bit_d = (ph_q == PH_W'(OSR - 1));
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      ph_q       <= '0;
      act_int_q  <= CNT_W'(DEF_INT);
      act_frac_q <= FRAC_W'(DEF_FRAC);
      shd_int_q  <= CNT_W'(DEF_INT);
      shd_frac_q <= FRAC_W'(DEF_FRAC);
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ph_q       <= ph_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
    end
  end

  assign os_tick  = os_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;
  assign os_phase = ph_q;
  assign cfg_err  = err_q;

endmodule
